// File: rtl/hermes_periph_arbiter.sv
// Shares one Hermes router port among N_SRC peripherals: round-robin outbound mux, header-decoded inbound demux.
// Define HERMES_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-first arbitration.
module hermes_periph_arbiter #(
  parameter int N_SRC     = 2,
  parameter int FLIT_SIZE = 32,
  parameter int SEL_LSB   = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                release_i,
  input  logic [N_SRC-1:0]                    src_tx_i,
  output logic [N_SRC-1:0]                    src_credit_o,
  input  logic [N_SRC-1:0][FLIT_SIZE-1:0]     src_data_i,
  output logic                                noc_tx_o,
  input  logic                                noc_credit_i,
  output logic [FLIT_SIZE-1:0]                noc_data_o,
  input  logic                                noc_rx_i,
  output logic                                noc_credit_o,
  input  logic [FLIT_SIZE-1:0]                noc_data_i,
  output logic [N_SRC-1:0]                    dst_rx_o,
  input  logic [N_SRC-1:0]                    dst_credit_i,
  output logic [N_SRC-1:0][FLIT_SIZE-1:0]     dst_data_o
);

  localparam int D_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  // The index field is a full byte so out-of-range destinations are visible and can be dropped.
  localparam int SEL_W = 8;
  localparam logic [SEL_W-1:0]     N_SEL   = SEL_W'(N_SRC);
  localparam logic [FLIT_SIZE-1:0] CNT_ONE = FLIT_SIZE'(1);
  localparam logic [D_W-1:0]       G_LAST  = D_W'(N_SRC - 1);

  typedef enum logic [1:0] {O_IDLE, O_HDR, O_SIZE, O_PAY} ostate_t;
  typedef enum logic [1:0] {I_IDLE, I_SIZE, I_PAY} istate_t;

  ostate_t              r_ost, w_ost_nxt;
  logic [D_W-1:0]       r_grant;
  logic [D_W-1:0]       w_pick;
  logic [D_W-1:0]       w_cand;
  logic                 w_found;
  int                   w_idx;
  logic [FLIT_SIZE-1:0] r_ocnt;
  logic                 w_oxfer;
`ifndef HERMES_ARB_FIXED_PRIO_EN
  logic [D_W-1:0]       r_ptr;
`endif

  istate_t              r_ist, w_ist_nxt;
  logic [D_W-1:0]       r_dst;
  logic                 r_drop;
  logic [FLIT_SIZE-1:0] r_icnt;
  logic [SEL_W-1:0]     w_field;
  logic                 w_hdr_ok;
  logic [D_W-1:0]       w_act_idx;
  logic                 w_act_drop;
  logic                 w_ixfer;

  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 0; k < N_SRC; k++) begin
`ifdef HERMES_ARB_FIXED_PRIO_EN
      w_idx = k;
`else
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_SRC) w_idx = w_idx - N_SRC;
`endif
      w_cand = D_W'(w_idx);
      if (!w_found && src_tx_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_oxfer = (r_ost != O_IDLE) & src_tx_i[r_grant] & release_i & noc_credit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ost <= O_IDLE;
    else         r_ost <= w_ost_nxt;
  end

  always_comb begin
    w_ost_nxt    = r_ost;
    noc_tx_o     = 1'b0;
    noc_data_o   = '0;
    src_credit_o = '0;
    case (r_ost)
      O_IDLE:  if (|src_tx_i) w_ost_nxt = O_HDR;
      O_HDR:   if (w_oxfer) w_ost_nxt = O_SIZE;
      O_SIZE:  if (w_oxfer) w_ost_nxt = (src_data_i[r_grant] != '0) ? O_PAY : O_IDLE;
      O_PAY:   if (w_oxfer && (r_ocnt == CNT_ONE)) w_ost_nxt = O_IDLE;
      default: w_ost_nxt = O_IDLE;
    endcase
    if (r_ost != O_IDLE) begin
      noc_tx_o              = src_tx_i[r_grant] & release_i;
      noc_data_o            = src_data_i[r_grant];
      src_credit_o[r_grant] = noc_credit_i & release_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grant <= '0;
      r_ocnt  <= '0;
`ifndef HERMES_ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      if ((r_ost == O_IDLE) && (|src_tx_i)) r_grant <= w_pick;
      if ((r_ost == O_SIZE) && w_oxfer)      r_ocnt <= src_data_i[r_grant];
      else if ((r_ost == O_PAY) && w_oxfer)  r_ocnt <= r_ocnt - CNT_ONE;
`ifndef HERMES_ARB_FIXED_PRIO_EN
      // Pointer moves past the source that just finished, giving the others first chance.
      if (w_oxfer && (w_ost_nxt == O_IDLE))
        r_ptr <= (r_grant == G_LAST) ? '0 : r_grant + D_W'(1);
`endif
    end
  end

  // Inbound: destination decoded live from the header while idle, then held for the packet.
  assign w_field    = noc_data_i[SEL_LSB +: SEL_W];
  assign w_hdr_ok   = (w_field < N_SEL);
  assign w_act_idx  = (r_ist == I_IDLE) ? w_field[D_W-1:0] : r_dst;
  assign w_act_drop = (r_ist == I_IDLE) ? !w_hdr_ok : r_drop;
  assign w_ixfer    = noc_rx_i & noc_credit_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ist <= I_IDLE;
    else         r_ist <= w_ist_nxt;
  end

  always_comb begin
    w_ist_nxt    = r_ist;
    noc_credit_o = 1'b0;
    dst_rx_o     = '0;
    case (r_ist)
      I_IDLE:  if (w_ixfer) w_ist_nxt = I_SIZE;
      I_SIZE:  if (w_ixfer) w_ist_nxt = (noc_data_i != '0) ? I_PAY : I_IDLE;
      I_PAY:   if (w_ixfer && (r_icnt == CNT_ONE)) w_ist_nxt = I_IDLE;
      default: w_ist_nxt = I_IDLE;
    endcase
    if (rst_ni) begin
      if (w_act_drop) begin
        noc_credit_o = release_i;
      end else begin
        noc_credit_o        = dst_credit_i[w_act_idx] & release_i;
        dst_rx_o[w_act_idx] = noc_rx_i & release_i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) dst_data_o[i] = rst_ni ? noc_data_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dst  <= '0;
      r_drop <= 1'b0;
      r_icnt <= '0;
    end else begin
      if ((r_ist == I_IDLE) && w_ixfer) begin
        r_dst  <= w_field[D_W-1:0];
        r_drop <= !w_hdr_ok;
      end
      if ((r_ist == I_SIZE) && w_ixfer)     r_icnt <= noc_data_i;
      else if ((r_ist == I_PAY) && w_ixfer) r_icnt <= r_icnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hermes_periph_arbiter.sv
// Directed bench for hermes_periph_arbiter (N_SRC=2, FLIT_SIZE=32, SEL_LSB=16).
module tb_hermes_periph_arbiter;
  localparam int N  = 2;
  localparam int FW = 32;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 release_i = 1'b1;
  logic [N-1:0]         src_tx_i = '0;
  logic [N-1:0]         src_credit_o;
  logic [N-1:0][FW-1:0] src_data_i = '0;
  logic                 noc_tx_o;
  logic                 noc_credit_i = 1'b1;
  logic [FW-1:0]        noc_data_o;
  logic                 noc_rx_i = 1'b0;
  logic                 noc_credit_o;
  logic [FW-1:0]        noc_data_i = '0;
  logic [N-1:0]         dst_rx_o;
  logic [N-1:0]         dst_credit_i = '0;
  logic [N-1:0][FW-1:0] dst_data_o;

  int checks = 0;
  int errors = 0;
  logic [0:0] g;

  always #5 clk = ~clk;

  hermes_periph_arbiter #(.N_SRC(N), .FLIT_SIZE(FW), .SEL_LSB(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .release_i(release_i),
    .src_tx_i(src_tx_i), .src_credit_o(src_credit_o), .src_data_i(src_data_i),
    .noc_tx_o(noc_tx_o), .noc_credit_i(noc_credit_i), .noc_data_o(noc_data_o),
    .noc_rx_i(noc_rx_i), .noc_credit_o(noc_credit_o), .noc_data_i(noc_data_i),
    .dst_rx_o(dst_rx_o), .dst_credit_i(dst_credit_i), .dst_data_o(dst_data_o)
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out_idle(input string tag);
    #1;
    chk({tag, " tx"}, FW'(noc_tx_o), 0);
    chk({tag, " cred"}, FW'(src_credit_o), 0);
    tick();
  endtask

  task automatic out_flit(input logic [0:0] s, input logic [FW-1:0] d, input string tag);
    src_data_i[s] = d;
    #1;
    chk({tag, " tx"}, FW'(noc_tx_o), 1);
    chk({tag, " data"}, noc_data_o, d);
    chk({tag, " cred"}, FW'(src_credit_o), FW'(1) << s);
    tick();
  endtask

  task automatic in_flit(input logic [FW-1:0] d, input logic exp_cred, input logic [N-1:0] exp_rx,
                         input string tag);
    noc_data_i = d;
    #1;
    chk({tag, " credit"}, FW'(noc_credit_o), FW'(exp_cred));
    chk({tag, " rx"}, FW'(dst_rx_o), FW'(exp_rx));
    chk({tag, " data"}, dst_data_o[1], d);
    tick();
  endtask

  initial begin
    // Reset with live-looking inputs: every output must still read 0.
    noc_rx_i     = 1'b1;
    noc_data_i   = 32'h0001_1234;
    dst_credit_i = 2'b11;
    src_data_i[0] = 32'hDEAD_0000;
    #2;
    chk("rst noc_tx", FW'(noc_tx_o), 0);
    chk("rst noc_credit", FW'(noc_credit_o), 0);
    chk("rst src_credit", FW'(src_credit_o), 0);
    chk("rst dst_rx", FW'(dst_rx_o), 0);
    chk("rst noc_data", noc_data_o, 0);
    chk("rst dst_data0", dst_data_o[0], 0);
    noc_rx_i   = 1'b0;
    noc_data_i = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // Single packet, size 3.
    src_tx_i = 2'b01;
    src_data_i[0] = 32'hA000_0001;
    out_idle("p1 req");
    out_flit(1'b0, 32'hA000_0001, "p1 hdr");
    out_flit(1'b0, 32'd3, "p1 size");
    out_flit(1'b0, 32'hB000_0001, "p1 pay1");
    out_flit(1'b0, 32'hB000_0002, "p1 pay2");
    out_flit(1'b0, 32'hB000_0003, "p1 pay3");
    src_tx_i = '0;
    out_idle("p1 end");

    // Both sources request continuously, size 1 each.
    src_tx_i = 2'b11;
    for (int p = 0; p < 4; p++) begin
`ifdef HERMES_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = (p % 2 == 0) ? 1'b1 : 1'b0;
`endif
      src_data_i[0] = 32'h1000_0000 + p;
      src_data_i[1] = 32'h2000_0000 + p;
      out_idle("rr idle");
      out_flit(g, (g ? 32'h2000_0000 : 32'h1000_0000) + p, "rr hdr");
      out_flit(g, 32'd1, "rr size");
      out_flit(g, 32'hCC00_0000 + p, "rr pay");
    end
    src_tx_i = '0;

    // Size-0 packet from src 1, then src 0 is arbitrated next.
    src_tx_i = 2'b10;
    src_data_i[1] = 32'h2000_00AA;
    out_idle("z idle");
    out_flit(1'b1, 32'h2000_00AA, "z hdr");
    out_flit(1'b1, 32'd0, "z size");
    src_tx_i = 2'b01;
    src_data_i[0] = 32'h1000_00BB;
    out_idle("z rearb");
    out_flit(1'b0, 32'h1000_00BB, "z2 hdr");
    out_flit(1'b0, 32'd0, "z2 size");
    src_tx_i = '0;
    out_idle("z2 end");

    // Release and credit stalls in the middle of a size-2 packet.
    src_tx_i = 2'b01;
    src_data_i[0] = 32'hA000_0002;
    out_idle("st idle");
    out_flit(1'b0, 32'hA000_0002, "st hdr");
    out_flit(1'b0, 32'd2, "st size");
    release_i = 1'b0;
    src_data_i[0] = 32'hE000_0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rel stall tx", FW'(noc_tx_o), 0);
      chk("rel stall cred", FW'(src_credit_o), 0);
      tick();
    end
    release_i = 1'b1;
    out_flit(1'b0, 32'hE000_0001, "st pay1");
    noc_credit_i = 1'b0;
    src_data_i[0] = 32'hE000_0002;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("cr stall cred", FW'(src_credit_o), 0);
      chk("cr stall tx", FW'(noc_tx_o), 1);
      chk("cr stall data", noc_data_o, 32'hE000_0002);
      tick();
    end
    noc_credit_i = 1'b1;
    out_flit(1'b0, 32'hE000_0002, "st pay2");
    src_tx_i = '0;
    out_idle("st end");

    // Inbound: d=1 delivered, d=5 dropped.
    noc_rx_i = 1'b1;
    dst_credit_i = 2'b11;
    in_flit(32'h0001_0055, 1'b1, 2'b10, "in1 hdr");
    in_flit(32'd2, 1'b1, 2'b10, "in1 size");
    dst_credit_i = 2'b01;
    in_flit(32'hF000_0001, 1'b0, 2'b10, "in1 stall");
    dst_credit_i = 2'b11;
    in_flit(32'hF000_0001, 1'b1, 2'b10, "in1 pay1");
    in_flit(32'hF000_0002, 1'b1, 2'b10, "in1 pay2");
    dst_credit_i = 2'b00;
    in_flit(32'h0005_0077, 1'b1, 2'b00, "in2 hdr");
    in_flit(32'd2, 1'b1, 2'b00, "in2 size");
    in_flit(32'hF000_0003, 1'b1, 2'b00, "in2 pay1");
    in_flit(32'hF000_0004, 1'b1, 2'b00, "in2 pay2");
    noc_rx_i = 1'b0;
    dst_credit_i = 2'b10;
    noc_data_i = 32'h0000_0000;
    #1;
    chk("in idle credit d0", FW'(noc_credit_o), 0);
    chk("in idle rx", FW'(dst_rx_o), 0);
    tick();

    // Reset in the middle of a payload, then a fresh packet.
    src_tx_i = 2'b10;
    src_data_i[1] = 32'h2000_0ABC;
    out_idle("rp idle");
    out_flit(1'b1, 32'h2000_0ABC, "rp hdr");
    out_flit(1'b1, 32'd3, "rp size");
    out_flit(1'b1, 32'hAB00_0001, "rp pay1");
    src_data_i[1] = 32'hAB00_0002;
    noc_rx_i = 1'b1;
    noc_data_i = 32'h0001_0000;
    dst_credit_i = 2'b11;
    rst_ni = 1'b0;
    #1;
    chk("mrst noc_tx", FW'(noc_tx_o), 0);
    chk("mrst noc_data", noc_data_o, 0);
    chk("mrst src_credit", FW'(src_credit_o), 0);
    chk("mrst noc_credit", FW'(noc_credit_o), 0);
    chk("mrst dst_rx", FW'(dst_rx_o), 0);
    chk("mrst dst_data1", dst_data_o[1], 0);
    tick();
    chk("mrst held tx", FW'(noc_tx_o), 0);
    noc_rx_i = 1'b0;
    src_tx_i = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    src_tx_i = 2'b11;
    src_data_i[0] = 32'h1000_0F00;
    src_data_i[1] = 32'h2000_0F00;
    out_idle("ar idle");
    out_flit(1'b0, 32'h1000_0F00, "ar hdr");
    out_flit(1'b0, 32'd1, "ar size");
    out_flit(1'b0, 32'h5A5A_0001, "ar pay");
    src_tx_i = '0;
    out_idle("ar end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
